irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt source block for the pipelined CPU: turns raw device request lines into prioritised, maskable, nestable interrupt requests with entrance addresses. It sits between the I/O request lines (`interrupt_signs`) and the CPU's CP0 logic. CP0 supplies mask and global-disable state and reports when an interrupt is taken or returned from. The controller tracks pending and in-service interrupts so the CPU never needs to.

## Interface
Parameters:
- `LINES`, 3, number of request lines; line `LINES-1` has highest priority.
- `ENT0`, 32'h0000_0800, entrance address for line 0.
- `ENT1`, 32'h0000_0600, entrance address for line 1.
- `ENT2`, 32'h0000_0400, entrance address for line 2.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `interrupt_signs`  in  LINES  raw device requests, synchronous to `clk`, edge-significant.
- `interrupt_mask`  in  LINES  per-line enable from CP0; 1 = enabled.
- `interrupt_disable`  in  1  global block from CP0; 1 = no new requests presented.
- `irq_take`  in  1  one-cycle pulse from the CPU when the PC is redirected to `irq_entrance`.
- `irq_ret`  in  1  one-cycle pulse when the CPU retires an exception return.
- `irq_req`  out  1  an interrupt is ready to be taken.
- `irq_id`  out  2  index of the presented line; 0 when `irq_req` = 0.
- `irq_entrance`  out  32  entrance address of `irq_id`; 32'h0 when `irq_req` = 0.
- `pending`  out  LINES  latched, not-yet-taken requests.
- `in_service`  out  LINES  lines currently being serviced (nesting stack).

## Operation
- Edge detect: `prev` register holds last-cycle `interrupt_signs`. A rising edge on line i (`interrupt_signs[i] & ~prev[i]`) sets `pending[i]`.
- Coalescing: an edge on a line already pending is absorbed, with no counting.
- Eligibility: line i is eligible when `pending[i] & interrupt_mask[i] & ~interrupt_disable` and i is strictly higher than the highest set `in_service` bit. Any eligible line qualifies when `in_service` = 0.
- Selection: the highest eligible line drives `irq_id` and `irq_entrance`. `irq_req` = any eligible.
- Take: on `irq_take` with `irq_req` = 1, clear `pending[irq_id]` and set `in_service[irq_id]`. `irq_take` with `irq_req` = 0 is ignored.
- Return: on `irq_ret`, clear the highest set `in_service` bit. `irq_ret` with `in_service` = 0 is ignored.
- Simultaneous take and return: `in_service_next = (in_service & ~highest_bit) | take_bit`. Both use pre-edge values.
- Simultaneous take and new edge on the same line: the edge wins, so `pending` stays 1.
- Masking: masking or disabling never clears `pending`. The request is presented again when re-enabled.
- Reset: `pending` = 0, `in_service` = 0, and `prev` loads the current `interrupt_signs`. Lines held high through reset therefore do not fire. All outputs are 0 in the cycle after reset.

## Timing
- `pending`, `in_service` and `prev` are registers. `irq_req`, `irq_id` and `irq_entrance` are combinational from those registers plus `interrupt_mask` and `interrupt_disable`.
- Request latency: an edge sampled at posedge k sets `pending` after posedge k, and `irq_req` is high in cycle k+1.
- After a take at posedge k, the taken line is no longer presented in cycle k+1. A lower line is not presented until its nesting level is returned.
- A return at posedge k makes lower lines eligible in cycle k+1.
- Mask or disable changes affect `irq_req` in the same cycle, with no register delay.
- `rst` overrides `irq_take`, `irq_ret` and edges in the same cycle.

## Test plan
- Single request: pulse `interrupt_signs` = 3'b001 at cycle 5, with mask 3'b111 and disable 0 -> `irq_req` = 1, `irq_id` = 0, `irq_entrance` = 32'h800 in cycle 6; `irq_take` at 8 -> `pending` = 0, `in_service` = 3'b001.
- Priority: edges on lines 0 and 1 in the same cycle -> `irq_id` = 1, entrance 32'h600; after take, line 0 is held off (`irq_req` = 0) until `irq_ret`, then `irq_id` = 0 the next cycle.
- Nesting: line 0 in service, line 2 edge -> `irq_req` = 1, `irq_id` = 2, entrance 32'h400; take -> `in_service` = 3'b101; one `irq_ret` -> 3'b001; second `irq_ret` -> 3'b000.
- Mask and disable: with `interrupt_mask` = 3'b000, a line-1 edge gives `pending` = 3'b010 and `irq_req` = 0; set mask 3'b010 -> `irq_req` = 1 the same cycle; `interrupt_disable` = 1 -> `irq_req` = 0 and `pending` is kept.
- Boundaries: take plus a new line-0 edge in the same cycle -> `pending[0]` stays 1; take plus `irq_ret` in the same cycle updates `in_service` per the combined rule; line held high two cycles -> one pending only.
- Reset: assert `rst` mid-service with `interrupt_signs` = 3'b100 held high -> `pending` = `in_service` = 0 and `irq_req` = 0 after release, with no spurious request until the line drops and rises again.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt source block: edge-detects device request lines, latches them as pending,
// and presents the highest eligible line with its entrance address under a nesting stack.
module irq_controller #(
   parameter int unsigned LINES = 3,
   parameter logic [31:0] ENT0  = 32'h0000_0800,
   parameter logic [31:0] ENT1  = 32'h0000_0600,
   parameter logic [31:0] ENT2  = 32'h0000_0400
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LINES-1:0] interrupt_signs,
   input  logic [LINES-1:0] interrupt_mask,
   input  logic             interrupt_disable,
   input  logic             irq_take,
   input  logic             irq_ret,
   output logic             irq_req,
   output logic [1:0]       irq_id,
   output logic [31:0]      irq_entrance,
   output logic [LINES-1:0] pending,
   output logic [LINES-1:0] in_service
);

   logic [LINES-1:0] prev_q, prev_d;
   logic [LINES-1:0] pending_q, pending_d;
   logic [LINES-1:0] in_service_q, in_service_d;

   logic [LINES-1:0] rise;
   logic [LINES-1:0] eligible;
   logic [LINES-1:0] take_bit;
   logic [LINES-1:0] ret_bit;
   logic [1:0]       sel;
   logic             blocked;
   logic             ret_found;

   assign rise = interrupt_signs & ~prev_q;

   // Walk from the top line down: once an in-service bit is seen, it and every
   // line below it are held off until that level returns.
   always_comb begin
      eligible  = '0;
      blocked   = 1'b0;
      ret_bit   = '0;
      ret_found = 1'b0;
      for (int unsigned k = 0; k < LINES; k++) begin
         blocked = blocked | in_service_q[LINES-1-k];
         eligible[LINES-1-k] = pending_q[LINES-1-k] & interrupt_mask[LINES-1-k]
                               & ~interrupt_disable & ~blocked;
         if (!ret_found && in_service_q[LINES-1-k]) begin
            ret_bit[LINES-1-k] = 1'b1;
            ret_found          = 1'b1;
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < LINES; i++) begin
         if (eligible[i]) sel = 2'(i);
      end
   end

   always_comb begin
      irq_req      = |eligible;
      irq_id       = irq_req ? sel : 2'd0;
      irq_entrance = '0;
      if (irq_req) begin
         case (sel)
            2'd0:    irq_entrance = ENT0;
            2'd1:    irq_entrance = ENT1;
            2'd2:    irq_entrance = ENT2;
            default: irq_entrance = '0;
         endcase
      end
   end

   always_comb begin
      take_bit = '0;
      if (irq_take && irq_req) take_bit[sel] = 1'b1;
   end

   // A new edge is ORed in after the take clears, so a same-cycle edge keeps the line pending.
   always_comb begin
      prev_d       = interrupt_signs;
      pending_d    = (pending_q & ~take_bit) | rise;
      in_service_d = (in_service_q & ~(irq_ret ? ret_bit : '0)) | take_bit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q       <= interrupt_signs;
         pending_q    <= '0;
         in_service_q <= '0;
      end else begin
         prev_q       <= prev_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   assign pending    = pending_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  interrupt_signs;
   logic [2:0]  interrupt_mask;
   logic        interrupt_disable;
   logic        irq_take;
   logic        irq_ret;
   logic        irq_req;
   logic [1:0]  irq_id;
   logic [31:0] irq_entrance;
   logic [2:0]  pending;
   logic [2:0]  in_service;

   typedef struct {
      string       name;
      logic        req;
      logic [1:0]  id;
      logic [31:0] ent;
      logic [2:0]  pend;
      logic [2:0]  svc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   irq_controller #(
      .LINES(3),
      .ENT0 (32'h0000_0800),
      .ENT1 (32'h0000_0600),
      .ENT2 (32'h0000_0400)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .interrupt_signs  (interrupt_signs),
      .interrupt_mask   (interrupt_mask),
      .interrupt_disable(interrupt_disable),
      .irq_take         (irq_take),
      .irq_ret          (irq_ret),
      .irq_req          (irq_req),
      .irq_id           (irq_id),
      .irq_entrance     (irq_entrance),
      .pending          (pending),
      .in_service       (in_service)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (irq_req !== e.req || irq_id !== e.id || irq_entrance !== e.ent ||
             pending !== e.pend || in_service !== e.svc) begin
            errors++;
            $display("FAIL %s: got req=%b id=%0d ent=%h pend=%b svc=%b, want req=%b id=%0d ent=%h pend=%b svc=%b",
                     e.name, irq_req, irq_id, irq_entrance, pending, in_service,
                     e.req, e.id, e.ent, e.pend, e.svc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic req, input logic [1:0] id,
                             input logic [31:0] ent, input logic [2:0] pend, input logic [2:0] svc);
      exp_t e;
      e.name = name; e.req = req; e.id = id; e.ent = ent; e.pend = pend; e.svc = svc;
      q.push_back(e);
   endtask

   task automatic idle(input string name);
      expect_out(name, 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
   endtask

   initial begin
      rst = 1'b1; interrupt_signs = '0; interrupt_mask = 3'b111;
      interrupt_disable = 1'b0; irq_take = 1'b0; irq_ret = 1'b0;
      step();
      idle("reset_state");
      rst = 1'b0;
      step();

      // single request
      interrupt_signs = 3'b001;
      idle("pre_edge");
      step(); interrupt_signs = '0;
      expect_out("single_req", 1, 0, 32'h800, 3'b001, 3'b000);
      step();
      expect_out("single_hold", 1, 0, 32'h800, 3'b001, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("single_take", 0, 0, 32'h0, 3'b000, 3'b001);
      irq_ret = 1; step(); irq_ret = 0;
      idle("single_ret");

      // take with nothing presented is ignored
      irq_take = 1; step(); irq_take = 0;
      idle("take_ignored");

      // priority
      interrupt_signs = 3'b011; step(); interrupt_signs = '0;
      expect_out("prio_sel", 1, 1, 32'h600, 3'b011, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("prio_holdoff", 0, 0, 32'h0, 3'b001, 3'b010);
      irq_ret = 1; step(); irq_ret = 0;
      expect_out("prio_after_ret", 1, 0, 32'h800, 3'b001, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("prio_take0", 0, 0, 32'h0, 3'b000, 3'b001);

      // nesting
      interrupt_signs = 3'b100; step(); interrupt_signs = '0;
      expect_out("nest_req", 1, 2, 32'h400, 3'b100, 3'b001);
      irq_take = 1; step(); irq_take = 0;
      expect_out("nest_take", 0, 0, 32'h0, 3'b000, 3'b101);
      irq_ret = 1; step(); irq_ret = 0;
      expect_out("nest_ret1", 0, 0, 32'h0, 3'b000, 3'b001);
      irq_ret = 1; step(); irq_ret = 0;
      idle("nest_ret2");

      // mask and disable
      interrupt_mask = 3'b000;
      interrupt_signs = 3'b010; step(); interrupt_signs = '0;
      expect_out("masked", 0, 0, 32'h0, 3'b010, 3'b000);
      step();
      interrupt_mask = 3'b010;
      expect_out("unmask_same_cycle", 1, 1, 32'h600, 3'b010, 3'b000);
      step();
      interrupt_disable = 1;
      expect_out("disabled", 0, 0, 32'h0, 3'b010, 3'b000);
      step();
      interrupt_disable = 0; interrupt_mask = 3'b111;
      expect_out("reenabled", 1, 1, 32'h600, 3'b010, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("mask_take", 0, 0, 32'h0, 3'b000, 3'b010);
      irq_ret = 1; step(); irq_ret = 0;
      idle("mask_ret");

      // take plus new edge on the same line
      interrupt_signs = 3'b001; step(); interrupt_signs = '0;
      expect_out("te_req", 1, 0, 32'h800, 3'b001, 3'b000);
      step();
      irq_take = 1; interrupt_signs = 3'b001; step(); irq_take = 0; interrupt_signs = '0;
      expect_out("take_edge", 0, 0, 32'h0, 3'b001, 3'b001);
      irq_ret = 1; step(); irq_ret = 0;
      expect_out("te_ret", 1, 0, 32'h800, 3'b001, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("te_take2", 0, 0, 32'h0, 3'b000, 3'b001);

      // take plus return in the same cycle
      interrupt_signs = 3'b100; step(); interrupt_signs = '0;
      expect_out("tr_req", 1, 2, 32'h400, 3'b100, 3'b001);
      irq_take = 1; irq_ret = 1; step(); irq_take = 0; irq_ret = 0;
      expect_out("take_ret", 0, 0, 32'h0, 3'b000, 3'b100);
      irq_ret = 1; step(); irq_ret = 0;
      idle("tr_ret");

      // line held high for several cycles coalesces
      interrupt_signs = 3'b010; step();
      expect_out("held_1", 1, 1, 32'h600, 3'b010, 3'b000);
      step();
      expect_out("held_2", 1, 1, 32'h600, 3'b010, 3'b000);
      interrupt_signs = '0; step();
      expect_out("held_drop", 1, 1, 32'h600, 3'b010, 3'b000);
      irq_take = 1; step(); irq_take = 0;
      expect_out("held_take", 0, 0, 32'h0, 3'b000, 3'b010);
      irq_ret = 1; step(); irq_ret = 0;
      idle("held_ret");

      // reset mid-service with a line held high
      interrupt_signs = 3'b001; step(); interrupt_signs = '0;
      irq_take = 1; step(); irq_take = 0;
      expect_out("rs_service", 0, 0, 32'h0, 3'b000, 3'b001);
      interrupt_signs = 3'b100; rst = 1; irq_ret = 1; step(); irq_ret = 0; rst = 0;
      idle("rst_mid_service");
      step();
      idle("rst_held_high");
      step();
      idle("rst_held_high2");
      interrupt_signs = '0; step();
      idle("rst_line_drop");
      interrupt_signs = 3'b100; step(); interrupt_signs = '0;
      expect_out("rst_new_edge", 1, 2, 32'h400, 3'b100, 3'b000);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past 100000 time units");
      $fatal(1);
   end

endmodule
